// File: rtl/led_msg_sequencer.sv
// led_msg_sequencer: loads an ASCII message over valid/ready and replays it on a 7-LED display
// with a character hold, optional blank gap and optional looping.
module led_msg_sequencer #(
   parameter int TICK_CNT = 25000000-1,
   parameter int GAP_CNT  = 2500000-1,
   parameter int DEPTH    = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [6:0]               wr_data,
   input  logic                     wr_last,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     loop_en,
   output logic [6:0]               led,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   msg_len
);
   localparam int PW = $clog2(DEPTH);
   localparam int TW = TICK_CNT > 0 ? $clog2(TICK_CNT+1) : 1;
   localparam int GW = GAP_CNT > 0 ? $clog2(GAP_CNT+1) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TICK_CNT);
   localparam logic [GW-1:0] GMAX = GW'(GAP_CNT);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t        state, state_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [GW-1:0] gcnt, gcnt_n;
   logic [PW-1:0] rd_ptr, rd_n, rd_inc, wr_ptr, wr_addr;
   logic [6:0]    led_n;
   logic [6:0]    mem [DEPTH];
   logic          done_n, loaded, adv, accept, term, more;

   assign busy     = state != IDLE;
   assign wr_ready = state == IDLE;
   assign accept   = wr_valid && wr_ready;
   // a write after a completed message restarts the buffer at address 0
   assign wr_addr  = loaded ? '0 : wr_ptr;
   assign term     = wr_last || wr_addr == PW'(DEPTH-1);
   assign rd_inc   = rd_ptr + 1'b1;
   assign more     = ({1'b0, rd_ptr} + 1'b1) < msg_len;

   always_ff @(posedge clk)
      if (accept) mem[wr_addr] <= wr_data;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr  <= '0;
         loaded  <= 1'b0;
         msg_len <= '0;
      end else if (accept) begin
         loaded <= term;
         wr_ptr <= term ? '0 : wr_addr + 1'b1;
         if (term) msg_len <= {1'b0, wr_addr} + 1'b1;
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state  <= IDLE;
         tcnt   <= '0;
         gcnt   <= '0;
         rd_ptr <= '0;
         led    <= 7'h7F;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         tcnt   <= tcnt_n;
         gcnt   <= gcnt_n;
         rd_ptr <= rd_n;
         led    <= led_n;
         done   <= done_n;
      end

   always_comb begin
      state_n = state;
      tcnt_n  = tcnt;
      gcnt_n  = gcnt;
      rd_n    = rd_ptr;
      led_n   = led;
      done_n  = 1'b0;
      adv     = 1'b0;
      case (state)
         IDLE:
            if (start && !stop && loaded) begin
               state_n = PLAY;
               tcnt_n  = '0;
               rd_n    = '0;
               led_n   = mem[0];
            end
         PLAY:
            if (tcnt != TMAX) tcnt_n = tcnt + 1'b1;
            else if (GAP_CNT == 0) adv = 1'b1;
            else begin
               state_n = GAP;
               gcnt_n  = '0;
               led_n   = 7'h00;
            end
         GAP:
            if (gcnt != GMAX) gcnt_n = gcnt + 1'b1;
            else adv = 1'b1;
         default: state_n = IDLE;
      endcase
      if (adv) begin
         state_n = (more || loop_en) ? PLAY : IDLE;
         tcnt_n  = '0;
         rd_n    = more ? rd_inc : '0;
         led_n   = more ? mem[rd_inc] : loop_en ? mem[0] : 7'h7F;
         done_n  = !more && !loop_en;
      end
      if (stop && state != IDLE) begin
         state_n = IDLE;
         led_n   = 7'h7F;
         done_n  = 1'b0;
      end
   end
endmodule

// File: tb/tb_led_msg_sequencer.sv
// tb_led_msg_sequencer: directed test-plan scenarios plus randomized playback, checked every
// cycle against a timeline model (character index and gap derived from cycles since start).
module tb_led_msg_sequencer;
   localparam int T = 4, G = 2, P = T + G;

   logic       clk = 0, rst = 0;
   logic       wr_valid = 0, wr_last = 0, start = 0, stop = 0, loop_en = 0;
   logic [6:0] wr_data = '0;
   logic       wr_ready, busy, done;
   logic [6:0] led;
   logic [3:0] msg_len;
   logic       b_wv = 0, b_wl = 0, b_start = 0;
   logic [6:0] b_wd = '0;
   logic       wr_ready2, busy2, done2;
   logic [6:0] led2;
   logic [3:0] msg_len2;

   led_msg_sequencer #(.TICK_CNT(3), .GAP_CNT(1), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .wr_last(wr_last), .start(start), .stop(stop), .loop_en(loop_en), .led(led),
      .busy(busy), .done(done), .msg_len(msg_len));

   led_msg_sequencer #(.TICK_CNT(3), .GAP_CNT(0), .DEPTH(8)) dut2 (
      .clk(clk), .rst(rst), .wr_valid(b_wv), .wr_ready(wr_ready2), .wr_data(b_wd),
      .wr_last(b_wl), .start(b_start), .stop(1'b0), .loop_en(1'b0), .led(led2),
      .busy(busy2), .done(done2), .msg_len(msg_len2));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: playback position m_j counts cycles since the pass began
   bit         m_play = 0, m_done = 0, m_loaded = 0;
   int         m_j = 0, m_wp = 0, m_len = 0;
   logic [6:0] m_mem [8] = '{default: 7'h00};

   task automatic model_edge();
      int a;
      m_done = 0;
      if (m_play) begin
         if (stop) m_play = 0;
         else begin
            m_j++;
            if (m_j == m_len * P) begin
               if (loop_en) m_j = 0;
               else begin
                  m_play = 0;
                  m_done = 1;
               end
            end
         end
      end else begin
         if (wr_valid) begin
            a = m_loaded ? 0 : m_wp;
            m_mem[a] = wr_data;
            if (wr_last || a == 7) begin
               m_len = a + 1;
               m_loaded = 1;
               m_wp = 0;
            end else begin
               m_wp = a + 1;
               m_loaded = 0;
            end
         end
         if (start && !stop && m_loaded) begin
            m_play = 1;
            m_j = 0;
         end
      end
   endtask

   function automatic logic [6:0] exp_led();
      return m_play ? (((m_j % P) < T) ? m_mem[m_j / P] : 7'h00) : 7'h7F;
   endfunction

   task automatic compare();
      chk("led", led, exp_led());
      chk("busy", busy, m_play);
      chk("wr_ready", wr_ready, !m_play);
      chk("done", done, m_done);
      chk("msg_len", msg_len, m_len);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1 compare();
   endtask

   task automatic write_char(input logic [6:0] d, input logic l);
      wr_valid = 1; wr_data = d; wr_last = l;
      cyc();
      wr_valid = 0; wr_last = 0;
   endtask

   task automatic b_write(input logic [6:0] d, input logic l);
      b_wv = 1; b_wd = d; b_wl = l;
      cyc();
      b_wv = 0; b_wl = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int n, len;
      repeat (2) @(posedge clk);
      #1 compare();
      chk("rst_led", led, 7'h7F);
      chk("rst_ready", wr_ready, 1);
      rst = 1;
      // 1: load and play
      write_char(7'h48, 0);
      write_char(7'h69, 1);
      chk("t1_len", msg_len, 2);
      start = 1; cyc(); start = 0;
      for (int c = 1; c <= 13; c++) begin
         chk("t1_led", led, c <= 4 ? 7'h48 : c <= 6 ? 7'h00 : c <= 10 ? 7'h69 : c <= 12 ? 7'h00 : 7'h7F);
         chk("t1_done", done, c == 13);
         if (c < 13) cyc();
      end
      chk("t1_busy", busy, 0);
      cyc();
      chk("t1_done_low", done, 0);
      // 2: loop, then drop loop_en
      loop_en = 1; start = 1; cyc(); start = 0;
      repeat (12) cyc();
      chk("t2_led_wrap", led, 7'h48);
      chk("t2_no_done", done, 0);
      loop_en = 0;
      n = 0;
      while (!done && n < 30) begin cyc(); n++; end
      chk("t2_done_lat", n, 12);
      // 3: stop has priority over start
      start = 1; cyc(); start = 0;
      repeat (7) cyc();
      stop = 1; start = 1; cyc(); stop = 0; start = 0;
      chk("t3_busy", busy, 0);
      chk("t3_led", led, 7'h7F);
      chk("t3_done", done, 0);
      chk("t3_len", msg_len, 2);
      start = 1; cyc(); start = 0;
      chk("t3_replay", led, 7'h48);
      // 4: write gating and auto-terminate
      wr_valid = 1; wr_data = 7'h55; wr_last = 1;
      chk("t4_ready", wr_ready, 0);
      repeat (3) cyc();
      wr_valid = 0; wr_last = 0;
      stop = 1; cyc(); stop = 0;
      chk("t4_len_kept", msg_len, 2);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("t4_len7", msg_len, 2);
         write_char(7'(8'h30 + i), 0);
      end
      chk("t4_len8", msg_len, 8);
      write_char(7'h41, 1);
      chk("t4_newmsg", msg_len, 1);
      start = 1; cyc(); start = 0;
      chk("t4_led", led, 7'h41);
      stop = 1; cyc(); stop = 0;
      // 5: reset during GAP, then start is ignored
      write_char(7'h48, 0);
      write_char(7'h69, 1);
      start = 1; cyc(); start = 0;
      repeat (4) cyc();
      chk("t5_gap", led, 7'h00);
      rst = 0;
      #1;
      m_play = 0; m_done = 0; m_loaded = 0; m_wp = 0; m_len = 0;
      compare();
      chk("t5_len", msg_len, 0);
      #2 rst = 1;
      start = 1; cyc(); start = 0;
      chk("t5_guard", busy, 0);
      // 6: no-gap variant
      b_write(7'h41, 0);
      b_write(7'h42, 0);
      b_write(7'h43, 1);
      chk("t6_len", msg_len2, 3);
      b_start = 1; cyc(); b_start = 0;
      for (int c = 1; c <= 13; c++) begin
         chk("t6_led", led2, c <= 4 ? 7'h41 : c <= 8 ? 7'h42 : c <= 12 ? 7'h43 : 7'h7F);
         chk("t6_done", done2, c == 13);
         if (c < 13) cyc();
      end
      chk("t6_busy", busy2, 0);
      chk("t6_ready", wr_ready2, 1);
      // randomized messages, loop toggling, stray writes/starts and stops
      for (int it = 0; it < 30; it++) begin
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++)
            write_char(7'($urandom), k == len - 1 && (len < 8 || $urandom % 2 == 1));
         loop_en = 1'($urandom);
         start = 1; cyc(); start = 0;
         for (int c = 0; c < 120 && m_play; c++) begin
            stop = ($urandom % 50 == 0);
            if ($urandom % 20 == 0) loop_en = ~loop_en;
            if ($urandom % 8 == 0) begin
               wr_valid = 1; wr_data = 7'($urandom); wr_last = 1'($urandom);
            end else start = ($urandom % 10 == 0);
            cyc();
            wr_valid = 0; wr_last = 0; start = 0; stop = 0;
         end
         stop = 1; cyc(); stop = 0; loop_en = 0;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
